branch_tracker: RTL and testbench
=================================

# branch_tracker

In-order tracker for conditional branches between fetch and commit. Records each predicted branch when the instruction fetcher issues it, accepts out-of-order resolutions from the branch ALU by tag, and retires entries in program order. On retirement it emits the 2-bit-counter update pulse (`upd_valid` / `upd_pc`, with `upd_pc[0]` = actual taken) that drives the predictor's update port. On a wrong prediction it also raises a one-cycle redirect/flush.

## Interface
- `DEPTH`, default 8: number of in-flight branch entries; must be a power of 2.
- `TAG_W`, default 3: log2(`DEPTH`).
- `clk_in` in 1: system clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global ready; when low, all state freezes.
- `alloc_valid` in 1: fetcher issues a branch this cycle.
- `alloc_pc` in 32: branch instruction PC.
- `alloc_len4` in 1: 1 = 32-bit instruction, 0 = 16-bit compressed.
- `alloc_pred_pc` in 32: next PC chosen by the predictor.
- `alloc_tag` out TAG_W: tag granted to the current alloc; equals the tail pointer (combinational).
- `full` out 1: no free entry.
- `res_valid` in 1: branch ALU resolution.
- `res_tag` in TAG_W: entry being resolved.
- `res_taken` in 1: actual direction.
- `res_target` in 32: actual taken target.
- `upd_valid` out 1: predictor update strobe.
- `upd_pc` out 32: `{pc[31:1], taken}`.
- `flush_valid` out 1: misprediction redirect strobe.
- `flush_pc` out 32: correct next PC.

## Operation
- **Storage.** Circular buffer of `DEPTH` entries. Each entry holds: pc, len4, pred_pc, resolved, taken, target. Pointers: head, tail, count (width TAG_W+1).
- **Alloc.**
  - Accepted at a clock edge when `alloc_valid && !full && rdy_in`.
  - Writes the entry at tail and clears its resolved bit; tail wraps modulo `DEPTH`.
  - `full` = (count == DEPTH), computed from registered count. A commit in the same cycle does not unblock an alloc.
- **Resolve.**
  - When `res_valid && rdy_in`, write taken/target and set resolved for `res_tag`.
  - Ignore the resolution if the slot is not live.
  - A resolve to the head slot does not commit in the same cycle.
- **Commit.** When the head entry is resolved (registered state) and `rdy_in` is high:
  - Retire the head: head+1, count−1.
  - Pulse `upd_valid` with `upd_pc = {pc[31:1], taken}`.
  - Compute actual_next = taken ? target : pc + (len4 ? 4 : 2), all arithmetic 32-bit wrap.
  - Mispredict when actual_next[31:1] != pred_pc[31:1]; bit 0 of pred_pc is ignored.
  - On mispredict, also pulse `flush_valid` with `flush_pc = {actual_next[31:1], 1'b0}`.
- **Flush.**
  - On the commit edge that raises `flush_valid`, the whole buffer empties: head = tail, count = 0.
  - Any alloc presented that cycle is dropped.
  - Resolves for the flushed tags in later cycles are ignored.
- **Simultaneous events.**
  - Alloc, resolve and non-flushing commit may all occur in one cycle. Count is adjusted by +1, −1, or 0 accordingly.

## Timing
- **Reset.**
  - Asynchronous, takes effect immediately.
  - head = tail = count = 0; all resolved bits cleared.
  - `upd_valid` = 0, `upd_pc` = 0, `flush_valid` = 0, `flush_pc` = 0.
  - `full` = 0; `alloc_tag` = 0.
  - Reset mid-operation discards all entries.
- **Output registration.** `upd_*` and `flush_*` are registered, one-cycle pulses.
- **Latency.** If a resolve is sampled at edge N, the earliest commit is edge N+1, so `upd_valid` is high in the cycle after edge N+1.
- **Throughput.** At most one commit per cycle.
- **`rdy_in` low.**
  - No pointer or entry changes.
  - Pulse outputs are forced to 0 in the following cycle.
  - Inputs are not sampled.
- **Empty buffer.** No commit occurs; outputs stay 0.

## Structure
- `const.v` gains `` `BT_DEPTH `` and `` `BT_TAG_W ``, shared with fetcher and ALU tag fields.
- Single module; no sub-module is needed. The pointer/count logic stays inline.

## Test plan
1. **Correct prediction.** Alloc pc=0x100, len4=1, pred_pc=0x104, then resolve not-taken. Expect `upd_valid` with `upd_pc`=0x100 and no flush.
2. **Taken mispredict.** Alloc pc=0x200, pred_pc=0x204, resolve taken with target 0x180. Expect `upd_pc`=0x201, `flush_pc`=0x180, and count 0 after the flush.
3. **Out-of-order resolution.** Alloc tags 0,1,2, resolve in order 2,0,1. Expect commits in tag order 0,1,2 on consecutive cycles.
4. **Full buffer.** Fill 8 entries: `full`=1 and a 9th alloc is ignored. Commit one; `full` drops the next cycle.
5. **Compressed fall-through.** Alloc pc=0x3FE, len4=0, pred_pc=0x401, resolve not-taken. Compare [31:1]: 0x400 vs 0x401 gives a match, so no flush and `upd_pc`=0x3FE.
6. **Reset and stall.**
   - Assert `rst_in` mid-stream: all outputs 0 immediately.
   - Hold `rdy_in` low with a resolved head: no `upd_valid` until `rdy_in` returns high.

Source files
------------

// File: rtl/branch_tracker_pkg.sv
// ---------------------------------------------------------------------------
// branch_tracker_pkg
//   Shared sizing constants and entry layout for the in-order branch tracker.
//   BT_DEPTH / BT_TAG_W are the values the fetcher and branch ALU use for
//   their tag fields, so all three agree on tag width.
//   Helpers compute the architecturally correct next PC of a retiring branch
//   and whether the predictor got it wrong.
// ---------------------------------------------------------------------------
package branch_tracker_pkg;

  localparam int BT_DEPTH = 8;
  localparam int BT_TAG_W = 3;

  // One in-flight branch. Only pred_pc[31:1] is kept because bit 0 of the
  // predicted PC never takes part in the mispredict comparison.
  typedef struct packed {
    logic [31:0] pc;
    logic        len4;
    logic [30:0] pred_hi;
    logic        resolved;
    logic        taken;
    logic [31:0] target;
  } bt_entry_t;

  // Correct next PC: taken target, or fall-through past a 4- or 2-byte
  // instruction. 32-bit wrap is intended.
  function automatic logic [31:0] bt_actual_next(input bt_entry_t e);
    logic [31:0] step;
    step = e.len4 ? 32'd4 : 32'd2;
    return e.taken ? e.target : (e.pc + step);
  endfunction

  // Mispredict when the halfword-aligned next PC differs from the prediction.
  function automatic logic bt_mispredict(input bt_entry_t e);
    logic [31:0] actual;
    actual = bt_actual_next(e);
    return (actual[31:1] != e.pred_hi);
  endfunction

endpackage

// File: rtl/branch_tracker.sv
// ---------------------------------------------------------------------------
// branch_tracker
//   In-order tracker for conditional branches between fetch and commit.
//   Entries are allocated at the tail in program order, resolved out of
//   order by tag from the branch ALU, and retired from the head once
//   resolved. Each retirement emits a predictor update pulse; a wrong
//   prediction additionally emits a redirect and empties the buffer.
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-high reset
//   rdy_in                 global ready; low freezes all state
//   alloc_valid/pc/len4/pred_pc   branch issued by the fetcher
//   alloc_tag              tag granted to the current alloc (tail pointer)
//   full                   no free entry (from registered count)
//   res_valid/tag/taken/target    resolution from the branch ALU
//   upd_valid, upd_pc      registered predictor update {pc[31:1], taken}
//   flush_valid, flush_pc  registered misprediction redirect
// ---------------------------------------------------------------------------
module branch_tracker
  import branch_tracker_pkg::*;
#(
  parameter int DEPTH = BT_DEPTH,
  parameter int TAG_W = BT_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_len4,
  input  logic [31:0]      alloc_pred_pc,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             flush_valid,
  output logic [31:0]      flush_pc
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);

  bt_entry_t        entry_q [DEPTH];
  bt_entry_t        entry_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic             upd_valid_q, upd_valid_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             flush_valid_q, flush_valid_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  bt_entry_t        head_entry_s;
  logic [31:0]      actual_next_s;
  logic             full_s;
  logic             commit_s;
  logic             flush_s;
  logic             alloc_s;
  logic             resolve_s;
  logic [TAG_W-1:0] res_off_s;

  // Bit 0 of the predicted PC is deliberately not stored.
  logic             unused_pred_lsb_s;
  assign unused_pred_lsb_s = alloc_pred_pc[0];

  assign full_s      = (count_q == DEPTH_CNT);
  assign full        = full_s;
  assign alloc_tag   = tail_q;
  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign flush_valid = flush_valid_q;
  assign flush_pc    = flush_pc_q;

  // Event decode: commit/flush from registered head state, gated alloc and resolve.
  always_comb begin
    head_entry_s  = entry_q[head_q];
    actual_next_s = bt_actual_next(head_entry_s);
    // Commit only looks at the registered resolved bit, so a resolve to the
    // head retires one cycle later.
    commit_s      = rdy_in && (count_q != '0) && head_entry_s.resolved;
    flush_s       = commit_s && bt_mispredict(head_entry_s);
    // A flushing commit drops the alloc presented in the same cycle.
    alloc_s       = rdy_in && alloc_valid && !full_s && !flush_s;
    // A tag is live when its distance from head (mod DEPTH) is below count;
    // stale or flushed tags fall outside that window and are ignored.
    res_off_s     = res_tag - head_q;
    resolve_s     = rdy_in && res_valid && ({1'b0, res_off_s} < count_q);
  end

  // Next-state for entries, pointers, count and registered pulse outputs.
  always_comb begin
    entry_d = entry_q;

    // Resolve only touches live slots and alloc only the free tail slot,
    // so these two writes never target the same entry.
    if (resolve_s) begin
      entry_d[res_tag].resolved = 1'b1;
      entry_d[res_tag].taken    = res_taken;
      entry_d[res_tag].target   = res_target;
    end else begin
      entry_d[res_tag] = entry_q[res_tag];
    end

    if (alloc_s) begin
      entry_d[tail_q].pc       = alloc_pc;
      entry_d[tail_q].len4     = alloc_len4;
      entry_d[tail_q].pred_hi  = alloc_pred_pc[31:1];
      entry_d[tail_q].resolved = 1'b0;
      entry_d[tail_q].taken    = 1'b0;
      entry_d[tail_q].target   = 32'h0000_0000;
    end else begin
      entry_d[tail_q] = entry_d[tail_q];
    end

    tail_d = alloc_s ? (tail_q + TAG_W'(1)) : tail_q;

    if (flush_s) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + TAG_W'(commit_s);
      count_d = count_q + (TAG_W + 1)'(alloc_s) - (TAG_W + 1)'(commit_s);
    end

    upd_valid_d   = commit_s;
    flush_valid_d = flush_s;
    if (commit_s) begin
      upd_pc_d = {head_entry_s.pc[31:1], head_entry_s.taken};
    end else begin
      upd_pc_d = 32'h0000_0000;
    end
    if (flush_s) begin
      flush_pc_d = {actual_next_s[31:1], 1'b0};
    end else begin
      flush_pc_d = 32'h0000_0000;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= 32'h0000_0000;
      flush_valid_q <= 1'b0;
      flush_pc_q    <= 32'h0000_0000;
    end else begin
      entry_q       <= entry_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      flush_valid_q <= flush_valid_d;
      flush_pc_q    <= flush_pc_d;
    end
  end

endmodule

// File: tb/tb_branch_tracker.sv
// ---------------------------------------------------------------------------
// tb_branch_tracker
//   Self-checking bench for branch_tracker. A queue of in-flight branches in
//   program order is the reference: commit pops its front, a mispredict
//   empties it, an alloc pushes at the back. Directed scenarios pin the
//   reference with literal values, then randomized traffic runs against it.
// ---------------------------------------------------------------------------
module tb_branch_tracker;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic        alloc_len4;
  logic [31:0] alloc_pred_pc;
  logic [2:0]  alloc_tag;
  logic        full;
  logic        res_valid;
  logic [2:0]  res_tag;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        flush_valid;
  logic [31:0] flush_pc;

  branch_tracker dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .rdy_in       (rdy),
    .alloc_valid  (alloc_valid),
    .alloc_pc     (alloc_pc),
    .alloc_len4   (alloc_len4),
    .alloc_pred_pc(alloc_pred_pc),
    .alloc_tag    (alloc_tag),
    .full         (full),
    .res_valid    (res_valid),
    .res_tag      (res_tag),
    .res_taken    (res_taken),
    .res_target   (res_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .flush_valid  (flush_valid),
    .flush_pc     (flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] pc;
    logic        len4;
    logic [31:0] pred;
    logic        resolved;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t        q[$];
  logic [2:0]  m_tail;
  logic        e_upd_v;
  logic [31:0] e_upd_pc;
  logic        e_fl_v;
  logic [31:0] e_fl_pc;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail   = 3'd0;
    e_upd_v  = 1'b0;
    e_upd_pc = 32'd0;
    e_fl_v   = 1'b0;
    e_fl_pc  = 32'd0;
  endtask

  // Advance the reference by one clock edge using the inputs now applied.
  task automatic model_step();
    logic        was_full;
    logic        do_commit;
    logic        mis;
    logic [31:0] nxt;
    if (rst) begin
      model_reset();
      return;
    end
    e_upd_v  = 1'b0;
    e_upd_pc = 32'd0;
    e_fl_v   = 1'b0;
    e_fl_pc  = 32'd0;
    if (!rdy) return;
    was_full  = (q.size() == DEPTH);
    do_commit = (q.size() > 0) && q[0].resolved;
    mis       = 1'b0;
    nxt       = 32'd0;
    if (do_commit) begin
      nxt = q[0].taken ? q[0].target : q[0].pc + (q[0].len4 ? 32'd4 : 32'd2);
      mis = (nxt[31:1] != q[0].pred[31:1]);
      e_upd_v  = 1'b1;
      e_upd_pc = {q[0].pc[31:1], q[0].taken};
    end
    if (res_valid) begin
      foreach (q[i]) begin
        if (q[i].tag == res_tag) begin
          q[i].resolved = 1'b1;
          q[i].taken    = res_taken;
          q[i].target   = res_target;
        end
      end
    end
    if (do_commit) begin
      void'(q.pop_front());
      if (mis) begin
        q.delete();
        e_fl_v  = 1'b1;
        e_fl_pc = {nxt[31:1], 1'b0};
      end
    end
    if (alloc_valid && !was_full && !(do_commit && mis)) begin
      q.push_back('{tag: m_tail, pc: alloc_pc, len4: alloc_len4, pred: alloc_pred_pc,
                    resolved: 1'b0, taken: 1'b0, target: 32'd0});
      m_tail = m_tail + 3'd1;
    end
  endtask

  // Step the reference, take the clock edge, then compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("upd_valid", upd_valid, e_upd_v);
    chk("upd_pc", upd_pc, e_upd_pc);
    chk("flush_valid", flush_valid, e_fl_v);
    chk("flush_pc", flush_pc, e_fl_pc);
    chk("full", full, (q.size() == DEPTH));
    chk("alloc_tag", alloc_tag, m_tail);
  endtask

  task automatic alloc1(input logic [31:0] pc, input logic len4, input logic [31:0] pred,
                        output logic [2:0] tag);
    tag           = m_tail;
    alloc_valid   = 1'b1;
    alloc_pc      = pc;
    alloc_len4    = len4;
    alloc_pred_pc = pred;
    tick();
    alloc_valid   = 1'b0;
  endtask

  task automatic resolve1(input logic [2:0] tag, input logic taken, input logic [31:0] tgt);
    res_valid  = 1'b1;
    res_tag    = tag;
    res_taken  = taken;
    res_target = tgt;
    tick();
    res_valid  = 1'b0;
  endtask

  task automatic randomize_inputs();
    logic [31:0] r;
    int          idx;
    rdy         = ($urandom_range(0, 9) != 0);
    alloc_valid = ($urandom_range(0, 2) != 0);
    r           = $urandom();
    alloc_pc    = {r[31:1], 1'b0};
    alloc_len4  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0:       alloc_pred_pc = alloc_pc + (alloc_len4 ? 32'd4 : 32'd2);
      1:       alloc_pred_pc = alloc_pc ^ 32'h0000_0040;
      default: alloc_pred_pc = $urandom();
    endcase
    alloc_pred_pc[0] = 1'($urandom_range(0, 1));
    res_valid = ($urandom_range(0, 9) < 6);
    res_taken = 1'($urandom_range(0, 1));
    if ((q.size() > 0) && ($urandom_range(0, 9) != 0)) begin
      idx        = $urandom_range(0, q.size() - 1);
      res_tag    = q[idx].tag;
      res_target = ($urandom_range(0, 1) != 0) ? q[idx].pred : $urandom();
    end else begin
      res_tag    = 3'($urandom_range(0, 7));
      res_target = $urandom();
    end
    rst = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    logic [2:0] t, ta, tb, t0, t1, t2;
    logic [2:0] tags [8];

    rst = 1'b1; rdy = 1'b1;
    alloc_valid = 1'b0; alloc_pc = 32'd0; alloc_len4 = 1'b0; alloc_pred_pc = 32'd0;
    res_valid = 1'b0; res_tag = 3'd0; res_taken = 1'b0; res_target = 32'd0;
    model_reset();
    #1;
    chk("rst_upd_valid", upd_valid, 32'd0);
    chk("rst_flush_valid", flush_valid, 32'd0);
    chk("rst_full", full, 32'd0);
    chk("rst_alloc_tag", alloc_tag, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Correct prediction, not taken
    alloc1(32'h100, 1'b1, 32'h104, t);
    resolve1(t, 1'b0, 32'd0);
    chk("t1_no_upd_yet", upd_valid, 32'd0);
    tick();
    chk("t1_upd_valid", upd_valid, 32'd1);
    chk("t1_upd_pc", upd_pc, 32'h100);
    chk("t1_flush", flush_valid, 32'd0);

    // Taken mispredict flushes a younger entry
    alloc1(32'h200, 1'b1, 32'h204, ta);
    alloc1(32'h300, 1'b1, 32'h304, tb);
    resolve1(ta, 1'b1, 32'h180);
    tick();
    chk("t2_upd_pc", upd_pc, 32'h201);
    chk("t2_flush_valid", flush_valid, 32'd1);
    chk("t2_flush_pc", flush_pc, 32'h180);
    chk("t2_count", q.size(), 32'd0);
    chk("t2_tag", alloc_tag, 32'd3);
    resolve1(tb, 1'b0, 32'd0);
    tick();
    chk("t2_stale_res", upd_valid, 32'd0);

    // Out-of-order resolution, in-order retirement
    alloc1(32'h500, 1'b1, 32'h504, t0);
    alloc1(32'h504, 1'b1, 32'h508, t1);
    alloc1(32'h508, 1'b1, 32'h50C, t2);
    resolve1(t2, 1'b0, 32'd0);
    resolve1(t0, 1'b0, 32'd0);
    resolve1(t1, 1'b0, 32'd0);
    chk("t3_c0", upd_pc, 32'h500);
    tick();
    chk("t3_c1", upd_pc, 32'h504);
    tick();
    chk("t3_c2", upd_pc, 32'h508);
    tick();
    chk("t3_idle", upd_valid, 32'd0);

    // Full buffer
    for (int i = 0; i < 8; i++) begin
      alloc1(32'h1000 + 32'(16 * i), 1'b1, 32'h1004 + 32'(16 * i), tags[i]);
    end
    chk("t4_full", full, 32'd1);
    alloc1(32'h2000, 1'b1, 32'h2004, t);
    chk("t4_full_hold", full, 32'd1);
    chk("t4_tag_wrap", alloc_tag, 32'(tags[0]));
    resolve1(tags[0], 1'b0, 32'd0);
    chk("t4_full_res", full, 32'd1);
    tick();
    chk("t4_full_drop", full, 32'd0);
    chk("t4_upd_pc", upd_pc, 32'h1000);
    for (int i = 7; i >= 1; i--) resolve1(tags[i], 1'b0, 32'd0);
    repeat (10) tick();

    // Compressed fall-through, pred bit 0 ignored
    alloc1(32'h3FE, 1'b0, 32'h401, t);
    resolve1(t, 1'b0, 32'd0);
    tick();
    chk("t5_upd_pc", upd_pc, 32'h3FE);
    chk("t5_flush", flush_valid, 32'd0);

    // Stall with a resolved head
    alloc1(32'h600, 1'b1, 32'h604, t);
    resolve1(t, 1'b0, 32'd0);
    rdy = 1'b0;
    repeat (3) begin
      tick();
      chk("t6_stall", upd_valid, 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("t6_resume", upd_valid, 32'd1);
    chk("t6_resume_pc", upd_pc, 32'h600);

    // Asynchronous reset mid-stream
    alloc1(32'h700, 1'b1, 32'h704, t0);
    alloc1(32'h704, 1'b1, 32'h708, t1);
    resolve1(t0, 1'b0, 32'd0);
    tick();
    chk("t6_pre_rst", upd_valid, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_upd_valid", upd_valid, 32'd0);
    chk("t6_rst_upd_pc", upd_pc, 32'd0);
    chk("t6_rst_tag", alloc_tag, 32'd0);
    chk("t6_rst_full", full, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    resolve1(t1, 1'b0, 32'd0);
    tick();
    chk("t6_post_rst", upd_valid, 32'd0);

    // Randomized traffic
    repeat (4000) begin
      randomize_inputs();
      tick();
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
